// File: rtl/uart_fifo_core.sv
// rtl/uart_fifo_core.sv - UART core with TX and RX FIFOs, optional parity
// The TX path drains its FIFO back-to-back. The RX path samples at mid-bit and pushes only good frames.
module uart_fifo_core #(
  parameter int DATA_W       = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              tx_full,
  output logic              tx,
  input  logic              rx,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rx_empty,
  output logic              rx_err,
  output logic              rx_ovf
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_BIT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam logic [AW:0]   DEPTH    = (AW+1)'(FIFO_DEPTH);
  localparam logic          PAR_ON   = (PARITY_EN != 0);
  localparam logic          ODD      = (PARITY_ODD != 0);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // TX FIFO
  logic [DATA_W-1:0] r_txq [FIFO_DEPTH];
  logic [AW-1:0]     r_txq_wp, r_txq_rp;
  logic [AW:0]       r_txq_cnt;
  logic              w_txq_push, w_txq_pop, w_txq_empty;

  assign w_txq_empty = (r_txq_cnt == '0);
  assign tx_full     = (r_txq_cnt == DEPTH);
  assign w_txq_push  = wr_en & ~tx_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txq_wp  <= '0;
      r_txq_rp  <= '0;
      r_txq_cnt <= '0;
    end else begin
      if (w_txq_push) r_txq_wp <= r_txq_wp + 1'b1;
      if (w_txq_pop)  r_txq_rp <= r_txq_rp + 1'b1;
      case ({w_txq_push, w_txq_pop})
        2'b10:   r_txq_cnt <= r_txq_cnt + 1'b1;
        2'b01:   r_txq_cnt <= r_txq_cnt - 1'b1;
        default: r_txq_cnt <= r_txq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_txq_push) r_txq[r_txq_wp] <= wr_data;
  end

  // TX FSM
  state_t            r_tx_state, w_tx_state_nxt;
  logic [CW-1:0]     r_tx_cnt, w_tx_cnt_nxt;
  logic [BW-1:0]     r_tx_bit, w_tx_bit_nxt;
  logic [DATA_W-1:0] r_tx_shift, w_tx_shift_nxt;
  logic              r_tx_par, w_tx_par_nxt;
  logic              r_tx, w_tx_nxt;
  logic              w_tx_bit_end;
  logic [DATA_W-1:0] w_txq_head;

  assign w_tx_bit_end = (r_tx_cnt == BIT_END);
  assign w_txq_head   = r_txq[r_txq_rp];
  assign tx           = r_tx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tx_state <= S_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_tx_shift <= '0;
      r_tx_par   <= 1'b0;
      r_tx       <= 1'b1;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_cnt   <= w_tx_cnt_nxt;
      r_tx_bit   <= w_tx_bit_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_tx_par   <= w_tx_par_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_cnt_nxt   = r_tx_cnt + 1'b1;
    w_tx_bit_nxt   = r_tx_bit;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_par_nxt   = r_tx_par;
    w_tx_nxt       = r_tx;
    w_txq_pop      = 1'b0;
    case (r_tx_state)
      S_IDLE: begin
        w_tx_cnt_nxt = '0;
        w_tx_nxt     = 1'b1;
        if (!w_txq_empty) begin
          w_txq_pop      = 1'b1;
          w_tx_state_nxt = S_START;
          w_tx_shift_nxt = w_txq_head;
          w_tx_par_nxt   = (^w_txq_head) ^ ODD;
          w_tx_nxt       = 1'b0;
        end
      end
      S_START: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_bit_nxt   = '0;
          w_tx_state_nxt = S_DATA;
          w_tx_nxt       = r_tx_shift[0];
        end
      end
      S_DATA: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt = '0;
          if (r_tx_bit == LAST_BIT) begin
            w_tx_state_nxt = PAR_ON ? S_PARITY : S_STOP;
            w_tx_nxt       = PAR_ON ? r_tx_par : 1'b1;
          end else begin
            w_tx_bit_nxt   = r_tx_bit + 1'b1;
            w_tx_shift_nxt = r_tx_shift >> 1;
            w_tx_nxt       = r_tx_shift[1];
          end
        end
      end
      S_PARITY: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt   = '0;
          w_tx_state_nxt = S_STOP;
          w_tx_nxt       = 1'b1;
        end
      end
      S_STOP: begin
        if (w_tx_bit_end) begin
          w_tx_cnt_nxt = '0;
          // Chain straight into the next start bit so queued bytes leave without a gap
          if (!w_txq_empty) begin
            w_txq_pop      = 1'b1;
            w_tx_state_nxt = S_START;
            w_tx_shift_nxt = w_txq_head;
            w_tx_par_nxt   = (^w_txq_head) ^ ODD;
            w_tx_nxt       = 1'b0;
          end else begin
            w_tx_state_nxt = S_IDLE;
            w_tx_nxt       = 1'b1;
          end
        end
      end
      default: w_tx_state_nxt = S_IDLE;
    endcase
  end

  // RX synchronizer; r_rx_s3 holds the previous synchronized value for edge detection
  logic r_rx_s1, r_rx_s2, r_rx_s3;
  logic w_rx_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  // RX FIFO
  logic [DATA_W-1:0] r_rxq [FIFO_DEPTH];
  logic [AW-1:0]     r_rxq_wp, r_rxq_rp;
  logic [AW:0]       r_rxq_cnt;
  logic              w_rxq_push, w_rxq_pop, w_rx_good;

  assign rx_empty   = (r_rxq_cnt == '0);
  assign rd_data    = rx_empty ? '0 : r_rxq[r_rxq_rp];
  assign w_rxq_pop  = rd_en & ~rx_empty;
  assign w_rxq_push = w_rx_good & ((r_rxq_cnt != DEPTH) | rd_en);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rxq_wp  <= '0;
      r_rxq_rp  <= '0;
      r_rxq_cnt <= '0;
    end else begin
      if (w_rxq_push) r_rxq_wp <= r_rxq_wp + 1'b1;
      if (w_rxq_pop)  r_rxq_rp <= r_rxq_rp + 1'b1;
      case ({w_rxq_push, w_rxq_pop})
        2'b10:   r_rxq_cnt <= r_rxq_cnt + 1'b1;
        2'b01:   r_rxq_cnt <= r_rxq_cnt - 1'b1;
        default: r_rxq_cnt <= r_rxq_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rxq_push) r_rxq[r_rxq_wp] <= r_rx_shift;
  end

  // RX FSM
  state_t            r_rx_state, w_rx_state_nxt;
  logic [CW-1:0]     r_rx_cnt, w_rx_cnt_nxt;
  logic [BW-1:0]     r_rx_bit, w_rx_bit_nxt;
  logic [DATA_W-1:0] r_rx_shift, w_rx_shift_nxt;
  logic              r_rx_pbit, w_rx_pbit_nxt;
  logic              r_rx_err, w_rx_err_nxt;
  logic              r_rx_ovf;
  logic              w_rx_bit_end, w_rx_par_ok;

  assign w_rx_bit_end = (r_rx_cnt == BIT_END);
  assign w_rx_par_ok  = !PAR_ON || (((^r_rx_shift) ^ r_rx_pbit) == ODD);
  assign rx_err       = r_rx_err;
  assign rx_ovf       = r_rx_ovf;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_state <= S_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_shift <= '0;
      r_rx_pbit  <= 1'b0;
      r_rx_err   <= 1'b0;
      r_rx_ovf   <= 1'b0;
    end else begin
      r_rx_state <= w_rx_state_nxt;
      r_rx_cnt   <= w_rx_cnt_nxt;
      r_rx_bit   <= w_rx_bit_nxt;
      r_rx_shift <= w_rx_shift_nxt;
      r_rx_pbit  <= w_rx_pbit_nxt;
      r_rx_err   <= w_rx_err_nxt;
      r_rx_ovf   <= w_rx_good & ~w_rxq_push;
    end
  end

  always_comb begin
    w_rx_state_nxt = r_rx_state;
    w_rx_cnt_nxt   = r_rx_cnt + 1'b1;
    w_rx_bit_nxt   = r_rx_bit;
    w_rx_shift_nxt = r_rx_shift;
    w_rx_pbit_nxt  = r_rx_pbit;
    w_rx_err_nxt   = 1'b0;
    w_rx_good      = 1'b0;
    case (r_rx_state)
      S_IDLE: begin
        w_rx_cnt_nxt = '0;
        if (w_rx_fall) w_rx_state_nxt = S_START;
      end
      S_START: begin
        if (r_rx_cnt == HALF_BIT) begin
          w_rx_cnt_nxt   = '0;
          w_rx_bit_nxt   = '0;
          w_rx_state_nxt = r_rx_s2 ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_nxt   = '0;
          w_rx_shift_nxt = {r_rx_s2, r_rx_shift[DATA_W-1:1]};
          if (r_rx_bit == LAST_BIT) w_rx_state_nxt = PAR_ON ? S_PARITY : S_STOP;
          else                      w_rx_bit_nxt   = r_rx_bit + 1'b1;
        end
      end
      S_PARITY: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_nxt   = '0;
          w_rx_pbit_nxt  = r_rx_s2;
          w_rx_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_rx_bit_end) begin
          w_rx_cnt_nxt   = '0;
          w_rx_state_nxt = S_IDLE;
          if (r_rx_s2 && w_rx_par_ok) w_rx_good    = 1'b1;
          else                        w_rx_err_nxt = 1'b1;
        end
      end
      default: w_rx_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_fifo_core.sv
// tb/tb_uart_fifo_core.sv - self-checking bench for uart_fifo_core
// Runs the frame vector table, the back-to-back, error, overflow and reset sequences, and a parity instance.
module tb_uart_fifo_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       wr_en, rd_en, rx, rx_drv, loop_en;
  logic [7:0] wr_data, rd_data;
  logic       tx_full, tx, rx_empty, rx_err, rx_ovf;

  logic       p_wr_en, p_rd_en, p_rx, p_rx_drv, p_loop_en;
  logic [7:0] p_wr_data, p_rd_data;
  logic       p_tx_full, p_tx, p_rx_empty, p_rx_err, p_rx_ovf;

  assign rx   = loop_en   ? tx   : rx_drv;
  assign p_rx = p_loop_en ? p_tx : p_rx_drv;

  uart_fifo_core #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_full(tx_full), .tx(tx),
    .rx(rx), .rd_en(rd_en), .rd_data(rd_data), .rx_empty(rx_empty), .rx_err(rx_err), .rx_ovf(rx_ovf)
  );

  uart_fifo_core #(.DATA_W(8), .FIFO_DEPTH(4), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_par (
    .clk(clk), .rst(rst), .wr_en(p_wr_en), .wr_data(p_wr_data), .tx_full(p_tx_full), .tx(p_tx),
    .rx(p_rx), .rd_en(p_rd_en), .rd_data(p_rd_data), .rx_empty(p_rx_empty), .rx_err(p_rx_err),
    .rx_ovf(p_rx_ovf)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int p_err_cnt = 0;
  logic [7:0] sb[$];

  always @(negedge clk) begin
    if (rx_err)   err_cnt++;
    if (rx_ovf)   ovf_cnt++;
    if (p_rx_err) p_err_cnt++;
  end

  typedef struct {
    logic [7:0]  data;
    logic [10:0] frame;
  } vec_t;
  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic cur_tx(input int sel);
    return (sel == 0) ? tx : p_tx;
  endfunction

  // Writes one byte into an idle TX path and samples each bit at its midpoint
  task automatic check_frame(input int sel, input logic [7:0] d, input int nbits,
                             input logic [10:0] exp, input string name);
    if (sel == 0) begin wr_data = d; wr_en = 1'b1; end
    else begin p_wr_data = d; p_wr_en = 1'b1; end
    tick();
    wr_en = 1'b0;
    p_wr_en = 1'b0;
    chk({name, "_idle_after_edge0"}, 32'(cur_tx(sel)), 1);
    tick();
    chk({name, "_start_after_edge1"}, 32'(cur_tx(sel)), 0);
    tick();
    for (int k = 0; k < nbits; k++) begin
      tick();
      chk($sformatf("%s_bit%0d", name, k), 32'(cur_tx(sel)), 32'(exp[nbits-1-k]));
      repeat (3) tick();
    end
  endtask

  task automatic rx_pop(input string name);
    int n = 0;
    while (rx_empty && n < 60) begin tick(); n++; end
    chk({name, "_rx_nonempty"}, 32'(rx_empty), 0);
    if (sb.size() == 0) begin
      chk({name, "_sb_has_entry"}, 0, 1);
    end else begin
      chk({name, "_rd_data"}, 32'(rd_data), 32'(sb.pop_front()));
    end
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic drive_bit(input int sel, input logic b);
    if (sel == 0) rx_drv = b;
    else p_rx_drv = b;
    repeat (4) tick();
  endtask

  task automatic send_rx(input int sel, input logic [7:0] d, input logic par_en,
                         input logic par_bit, input logic stop_bit);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (par_en) drive_bit(sel, par_bit);
    drive_bit(sel, stop_bit);
    if (sel == 0) rx_drv = 1'b1;
    else p_rx_drv = 1'b1;
    repeat (8) tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, o0, zeros, n;
    logic [7:0] d;
    logic       eb;

    vecs[0] = '{data: 8'hA5, frame: 11'b00101001011};
    vecs[1] = '{data: 8'h00, frame: 11'b00000000001};
    vecs[2] = '{data: 8'hFF, frame: 11'b00111111111};
    vecs[3] = '{data: 8'h3C, frame: 11'b00001111001};
    vecs[4] = '{data: 8'h81, frame: 11'b00100000011};

    rst = 1'b0;
    wr_en = 1'b0; wr_data = '0; rd_en = 1'b0; rx_drv = 1'b1; loop_en = 1'b0;
    p_wr_en = 1'b0; p_wr_data = '0; p_rd_en = 1'b0; p_rx_drv = 1'b1; p_loop_en = 1'b0;
    repeat (3) tick();
    chk("rst_tx", 32'(tx), 1);
    chk("rst_tx_full", 32'(tx_full), 0);
    chk("rst_rx_empty", 32'(rx_empty), 1);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_rx_err", 32'(rx_err), 0);
    chk("rst_rx_ovf", 32'(rx_ovf), 0);
    rst = 1'b1;
    repeat (2) tick();

    // Frame table with tx looped back to rx
    loop_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(vecs[i].data);
      check_frame(0, vecs[i].data, 10, vecs[i].frame, $sformatf("vec%0d", i));
      rx_pop($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_rx_empty_after_pop", i), 32'(rx_empty), 1);
    end
    chk("loop_no_err", 32'(err_cnt), 0);
    loop_en = 1'b0;
    repeat (4) tick();

    // Six back-to-back writes: fifth fills the FIFO, sixth is dropped
    for (int c = 0; c < 210; c++) begin
      wr_en = (c < 6);
      wr_data = 8'(c);
      tick();
      wr_en = 1'b0;
      if (c == 3)  chk("b2b_full_after_4th", 32'(tx_full), 0);
      if (c == 4)  chk("b2b_full_after_5th", 32'(tx_full), 1);
      if (c == 40) chk("b2b_full_before_2nd_pop", 32'(tx_full), 1);
      if (c == 41) chk("b2b_full_after_2nd_pop", 32'(tx_full), 0);
      if (c >= 3 && ((c - 3) % 4) == 0 && ((c - 3) / 4) < 50) begin
        n = (c - 3) / 4;
        d = 8'(n / 10);
        if ((n % 10) == 0)      eb = 1'b0;
        else if ((n % 10) == 9) eb = 1'b1;
        else                    eb = d[(n % 10) - 1];
        chk($sformatf("b2b_bit%0d", n), 32'(tx), 32'(eb));
      end
    end
    zeros = 0;
    for (int c = 0; c < 48; c++) begin
      tick();
      if (!tx) zeros++;
    end
    chk("b2b_sixth_dropped", 32'(zeros), 0);
    chk("b2b_tx_full_end", 32'(tx_full), 0);

    // Stop bit driven low
    e0 = err_cnt;
    send_rx(0, 8'h3C, 1'b0, 1'b0, 1'b0);
    chk("frame_err_pulse", 32'(err_cnt), 32'(e0 + 1));
    chk("frame_err_rx_empty", 32'(rx_empty), 1);

    // Directly driven good frame
    sb.push_back(8'h5A);
    send_rx(0, 8'h5A, 1'b0, 1'b0, 1'b1);
    rx_pop("drv5a");

    // Overflow on the fifth unread frame
    e0 = err_cnt;
    o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      d = 8'(8'h11 * (i + 1));
      if (i < 4) sb.push_back(d);
      send_rx(0, d, 1'b0, 1'b0, 1'b1);
      if (i == 3) chk("ovf_none_after_4", 32'(ovf_cnt), 32'(o0));
    end
    chk("ovf_pulse_on_5th", 32'(ovf_cnt), 32'(o0 + 1));
    chk("ovf_no_err", 32'(err_cnt), 32'(e0));
    for (int i = 0; i < 4; i++) rx_pop($sformatf("ovf_rd%0d", i));
    chk("ovf_drained", 32'(rx_empty), 1);

    // One-clock glitch must not start a frame
    rx_drv = 1'b0;
    tick();
    rx_drv = 1'b1;
    repeat (50) tick();
    chk("glitch_rx_empty", 32'(rx_empty), 1);
    chk("glitch_no_err", 32'(err_cnt), 32'(e0));

    // Parity instance: even parity of 0x07 is 1
    p_loop_en = 1'b1;
    check_frame(1, 8'h07, 11, 11'b01110000011, "par07");
    n = 0;
    while (p_rx_empty && n < 60) begin tick(); n++; end
    chk("par07_rx_nonempty", 32'(p_rx_empty), 0);
    chk("par07_rd_data", 32'(p_rd_data), 32'h07);
    p_rd_en = 1'b1;
    tick();
    p_rd_en = 1'b0;
    p_loop_en = 1'b0;
    repeat (4) tick();
    e0 = p_err_cnt;
    send_rx(1, 8'h07, 1'b1, 1'b0, 1'b1);
    chk("par_bad_err_pulse", 32'(p_err_cnt), 32'(e0 + 1));
    chk("par_bad_discarded", 32'(p_rx_empty), 1);
    send_rx(1, 8'h3C, 1'b1, 1'b0, 1'b1);
    chk("par_good_no_err", 32'(p_err_cnt), 32'(e0 + 1));
    chk("par_good_rx_nonempty", 32'(p_rx_empty), 0);
    chk("par_good_rd_data", 32'(p_rd_data), 32'h3C);

    // Reset during TX DATA, then a clean frame
    wr_data = 8'h00;
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
    repeat (8) tick();
    chk("mid_rst_tx_low_before", 32'(tx), 0);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_tx_high", 32'(tx), 1);
    chk("mid_rst_tx_full", 32'(tx_full), 0);
    chk("mid_rst_rx_empty", 32'(rx_empty), 1);
    chk("mid_rst_rd_data", 32'(rd_data), 0);
    repeat (2) tick();
    rst = 1'b1;
    repeat (2) tick();
    loop_en = 1'b1;
    sb.push_back(8'h81);
    check_frame(0, 8'h81, 10, 11'b00100000011, "post_rst");
    rx_pop("post_rst");
    chk("sb_empty_at_end", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_fifo_core.md
UART_FIFO_CORE -- requirements
Module: uart_fifo_core

Interface
REQ-001 SHALL provide parameter DATA_W, 8, data bits per frame, range 5..9.
REQ-002 SHALL provide parameter FIFO_DEPTH, 4, entries per TX and RX FIFO, power of two, at least 2.
REQ-003 SHALL provide parameter CLKS_PER_BIT, 16, clk cycles per bit, at least 4.
REQ-004 SHALL provide parameter PARITY_EN, 0, 1 inserts and checks a parity bit after the data bits.
REQ-005 SHALL provide parameter PARITY_ODD, 0, 1 selects odd parity, 0 selects even parity.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-low reset.
REQ-008 wr_en  input  1  push wr_data into the TX FIFO.
REQ-009 wr_data  input  DATA_W  byte to transmit.
REQ-010 tx_full  output  1  TX FIFO holds FIFO_DEPTH entries.
REQ-011 tx  output  1  serial out, registered, idle high.
REQ-012 rx  input  1  serial in, asynchronous to clk.
REQ-013 rd_en  input  1  pop the RX FIFO head.
REQ-014 rd_data  output  DATA_W  RX FIFO head (show-ahead); valid while rx_empty=0.
REQ-015 rx_empty  output  1  RX FIFO holds no entries.
REQ-016 rx_err  output  1  one-cycle pulse on a framing or parity error.
REQ-017 rx_ovf  output  1  one-cycle pulse when a good frame is dropped because the RX FIFO is full.

Function
REQ-018 TX FIFO SHALL accept a write only when wr_en=1 and tx_full=0; a write while full SHALL be ignored and SHALL leave contents unchanged.
REQ-019 TX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; PARITY SHALL be skipped when PARITY_EN=0.
REQ-020 In IDLE with the TX FIFO non-empty, the FSM SHALL pop the head and enter START on the same edge; tx SHALL be low after that edge.
REQ-021 With wr_en sampled at edge 0 into an empty idle TX path, tx SHALL be low after edge 1.
REQ-022 Each bit SHALL last exactly CLKS_PER_BIT cycles; data bits SHALL be sent LSB first; STOP SHALL drive 1 for one bit time.
REQ-023 The parity bit SHALL equal XOR of the data bits, inverted when PARITY_ODD=1.
REQ-024 At the end of STOP, the FSM SHALL go to START when the FIFO is non-empty, with no idle gap, and to IDLE otherwise.
REQ-025 rx SHALL pass through a 2-flop synchronizer before any use.
REQ-026 RX FSM SHALL have states IDLE, START, DATA, PARITY, STOP; in IDLE a synchronized falling edge SHALL enter START.
REQ-027 In START, rx SHALL be resampled at CLKS_PER_BIT/2; if high, the FSM SHALL return to IDLE (glitch rejection) with no error.
REQ-028 Data, parity and stop bits SHALL each be sampled once, CLKS_PER_BIT cycles after the previous sample.
REQ-029 Stop sample = 0 or parity mismatch SHALL discard the frame, pulse rx_err and return to IDLE.
REQ-030 A good frame SHALL be pushed at the stop-sample edge; rx_empty SHALL fall after that edge.
REQ-031 Push into a full RX FIFO SHALL succeed if rd_en=1 in the same cycle; otherwise the frame SHALL be dropped and rx_ovf pulsed.
REQ-032 rd_en with rx_empty=1 SHALL be ignored.
REQ-033 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL be tracked so that full and empty are unambiguous.

Reset
REQ-034 While rst=0, the block SHALL hold tx=1, tx_full=0, rx_empty=1, rd_data=0, rx_err=0, rx_ovf=0, both FIFOs empty and both FSMs in IDLE.
REQ-035 Reset asserted mid-frame SHALL abort the frame; tx SHALL go high asynchronously and no partial byte SHALL be stored.

Verification (DATA_W=8, FIFO_DEPTH=4, CLKS_PER_BIT=4 unless stated)
REQ-036 Write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, 4 clk each; with tx looped to rx, rd_data=0xA5 and rx_empty=0 after the stop sample.
REQ-037 Six back-to-back writes 0x00..0x05 -> tx_full=1 after the fifth; 0x05 dropped; 0x00..0x04 sent with no inter-frame gap.
REQ-038 rx frame 0x3C with stop bit driven 0 -> one-cycle rx_err pulse; rx_empty stays 1.
REQ-039 PARITY_EN=1, PARITY_ODD=0: write 0x07 -> parity bit 1; an rx frame with parity bit 0 -> rx_err pulse, frame discarded.
REQ-040 Five good rx frames with no reads -> rx_ovf pulses on the fifth; reads return the first four bytes in order; rx low for 1 clk only -> no frame.
REQ-041 rst pulsed low during TX DATA -> tx=1 immediately, tx_full=0, and the next write transmits a complete frame.
